// File: rtl/nbody_pkg.sv
// Shared types and constants for the n-body force drain: force format,
// drain FSM encoding and saturation bounds.
package nbody_pkg;

  localparam int FW_DEF    = 32;
  localparam int IDX_W_DEF = 2;

  typedef logic signed [FW_DEF-1:0] force_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } drain_state_e;

  localparam force_t SAT_MAX = {1'b0, {(FW_DEF-1){1'b1}}};
  localparam force_t SAT_MIN = {1'b1, {(FW_DEF-1){1'b0}}};

endpackage

// File: rtl/nbody_sat_add.sv
// Three-operand signed saturating adder: acc plus up to two enabled
// contributions, summed at FW+2 bits and clamped back to FW bits.
module nbody_sat_add #(
  parameter int FW = nbody_pkg::FW_DEF
) (
  input  logic signed [FW-1:0] acc,
  input  logic signed [FW-1:0] a,
  input  logic                 en_a,
  input  logic signed [FW-1:0] b,
  input  logic                 en_b,
  output logic signed [FW-1:0] sum,
  output logic                 sat
);

  localparam logic signed [FW+1:0] MAX_W = {3'b000, {(FW-1){1'b1}}};
  localparam logic signed [FW+1:0] MIN_W = {3'b111, {(FW-1){1'b0}}};

  logic signed [FW+1:0] wide;

  always_comb begin
    wide = $signed({{2{acc[FW-1]}}, acc});
    if (en_a) wide = wide + $signed({{2{a[FW-1]}}, a});
    if (en_b) wide = wide + $signed({{2{b[FW-1]}}, b});
    sum = wide[FW-1:0];
    sat = 1'b0;
    if (wide > MAX_W) begin
      sum = MAX_W[FW-1:0];
      sat = 1'b1;
    end else if (wide < MIN_W) begin
      sum = MIN_W[FW-1:0];
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/nbody_force_drain.sv
// Collects right/bottom edge partial forces of the systolic array, accumulates
// them per body over a frame, then streams the totals out in index order.
module nbody_force_drain
  import nbody_pkg::*;
#(
  parameter int N_BODIES = 4,
  parameter int BLOCK    = 2,
  parameter int FW       = FW_DEF,
  parameter int IDX_W    = $clog2(N_BODIES)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    frame_start,
  input  logic                    frame_done,
  input  logic [BLOCK-1:0]        pr_valid,
  input  logic [BLOCK*FW-1:0]     pr_data,
  input  logic [IDX_W-1:0]        pr_base,
  input  logic [BLOCK-1:0]        pd_valid,
  input  logic [BLOCK*FW-1:0]     pd_data,
  input  logic [IDX_W-1:0]        pd_base,
  output logic                    acc_valid,
  input  logic                    acc_ready,
  output logic [IDX_W-1:0]        acc_idx,
  output logic signed [FW-1:0]    acc_force,
  output logic                    busy,
  output logic                    sat_flag,
  output logic                    proto_err
);

  // Handshake: a beat moves on any posedge where acc_valid && acc_ready;
  // acc_idx/acc_force stay frozen while acc_valid && !acc_ready.

  drain_state_e state;

  logic signed [FW-1:0] acc_q [N_BODIES];
  logic signed [FW-1:0] r_con [N_BODIES];
  logic signed [FW-1:0] d_con [N_BODIES];
  logic signed [FW-1:0] sum_w [N_BODIES];
  logic [N_BODIES-1:0]  r_en, d_en, sat_w;
  logic                 lane_oob;
  logic                 lanes_any;

  assign lanes_any = (|pr_valid) | (|pd_valid);

  // Route each valid lane to its body; lanes past the last body are dropped.
  always_comb begin
    lane_oob = 1'b0;
    r_en     = '0;
    d_en     = '0;
    for (int i = 0; i < N_BODIES; i++) begin
      r_con[i] = '0;
      d_con[i] = '0;
    end
    for (int k = 0; k < BLOCK; k++) begin
      if (pr_valid[k] && (int'(pr_base) + k >= N_BODIES)) lane_oob = 1'b1;
      if (pd_valid[k] && (int'(pd_base) + k >= N_BODIES)) lane_oob = 1'b1;
      for (int i = 0; i < N_BODIES; i++) begin
        if (pr_valid[k] && (int'(pr_base) + k == i)) begin
          r_en[i]  = 1'b1;
          r_con[i] = pr_data[k*FW +: FW];
        end
        if (pd_valid[k] && (int'(pd_base) + k == i)) begin
          d_en[i]  = 1'b1;
          d_con[i] = pd_data[k*FW +: FW];
        end
      end
    end
  end

  for (genvar g = 0; g < N_BODIES; g++) begin : g_body
    nbody_sat_add #(.FW(FW)) u_add (
      .acc  (acc_q[g]),
      .a    (r_con[g]),
      .en_a (r_en[g]),
      .b    (d_con[g]),
      .en_b (d_en[g]),
      .sum  (sum_w[g]),
      .sat  (sat_w[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      for (int i = 0; i < N_BODIES; i++) acc_q[i] <= '0;
      acc_valid <= 1'b0;
      acc_idx   <= '0;
      acc_force <= '0;
      busy      <= 1'b0;
      sat_flag  <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (frame_start) begin
            state     <= ACCUM;
            busy      <= 1'b1;
            for (int i = 0; i < N_BODIES; i++) acc_q[i] <= '0;
            sat_flag  <= 1'b0;
            proto_err <= lanes_any | frame_done;
          end else if (lanes_any || frame_done) begin
            proto_err <= 1'b1;
          end
        end
        ACCUM: begin
          if (frame_start) begin
            proto_err <= 1'b1;
            for (int i = 0; i < N_BODIES; i++) acc_q[i] <= '0;
          end else begin
            for (int i = 0; i < N_BODIES; i++) acc_q[i] <= sum_w[i];
            if (|sat_w) sat_flag <= 1'b1;
            if (lane_oob) proto_err <= 1'b1;
            if (frame_done) begin
              // Same-cycle lanes are already folded into sum_w.
              state     <= DRAIN;
              acc_valid <= 1'b1;
              acc_idx   <= '0;
              acc_force <= sum_w[0];
            end
          end
        end
        DRAIN: begin
          if (lanes_any || frame_start || frame_done) proto_err <= 1'b1;
          if (acc_ready) begin
            if (acc_idx == IDX_W'(N_BODIES-1)) begin
              state     <= IDLE;
              busy      <= 1'b0;
              acc_valid <= 1'b0;
              acc_idx   <= '0;
            end else begin
              acc_idx   <= acc_idx + 1'b1;
              acc_force <= acc_q[acc_idx + 1'b1];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
